// File: rtl/addsub_bcd_fnd_scan.sv
// addsub_bcd_fnd_scan: WIDTH-bit add/subtract with carry/borrow, sequential
// double-dabble conversion of the signed result to BCD, and a multiplexed
// common-anode 7-segment scan with the top position reserved for the sign.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module addsub_bcd_fnd_scan #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_c,
    output logic [DIGITS-1:0] o_digit,
    output logic [7:0]        o_font
);

    localparam int unsigned NW = 4 * (DIGITS - 1);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned KW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StConv, StDone} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic [WIDTH:0]   bin_q, bin_d;
    logic [NW-1:0]    bcd_q, bcd_d;
    logic             neg_q, neg_d;
    logic             cc_q, cc_d;
    logic [KW-1:0]    cnt_q, cnt_d;
    logic [NW-1:0]    disp_q, disp_d;
    logic             disp_neg_q, disp_neg_d;
    logic             c_q, c_d;
    logic [CW-1:0]    scan_q, scan_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [7:0]       font_q, font_d;

    logic [WIDTH:0]   sum;
    logic [NW-1:0]    adj;
    logic [3:0]       nib;
    logic             blank;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // FSM next-state logic; i_start only matters in idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_start) state_d = StCalc;
            StCalc: state_d = StConv;
            StConv: if (cnt_q == KW'(WIDTH)) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy = (state_q != StIdle);
        o_done = (state_q == StDone);
    end

    // Datapath: operand latch, add/sub, one double-dabble shift per CONV cycle
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        cc_d       = cc_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        disp_neg_d = disp_neg_q;
        c_d        = c_q;
        sum        = '0;
        adj        = bcd_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    a_d    = i_a;
                    b_d    = i_b;
                    mode_d = i_mode;
                end
            end
            StCalc: begin
                if (!mode_q) begin
                    sum   = {1'b0, a_q} + {1'b0, b_q};
                    bin_d = sum;
                    neg_d = 1'b0;
                    cc_d  = sum[WIDTH];
                end else if (a_q >= b_q) begin
                    bin_d = {1'b0, a_q - b_q};
                    neg_d = 1'b0;
                    cc_d  = 1'b0;
                end else begin
                    bin_d = {1'b0, b_q - a_q};
                    neg_d = 1'b1;
                    cc_d  = 1'b1;
                end
                bcd_d = '0;
                cnt_d = '0;
            end
            StConv: begin
                for (int k = 0; k < int'(DIGITS - 1); k++) begin
                    if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
                end
                // Digits shifted out above the BCD register are dropped
                bcd_d = {adj[NW-2:0], bin_q[WIDTH]};
                bin_d = {bin_q[WIDTH-1:0], 1'b0};
                cnt_d = cnt_q + KW'(1);
                // Display and carry change on the edge that enters DONE
                if (cnt_q == KW'(WIDTH)) begin
                    disp_d     = {adj[NW-2:0], bin_q[WIDTH]};
                    disp_neg_d = neg_q;
                    c_d        = cc_q;
                end
            end
            StDone: ;
            default: ;
        endcase
    end

    // Scan counter, digit index and font; font uses next-state display so a
    // new result shows up on the same edge that raises o_done
    always_comb begin
        scan_d = scan_q + CW'(1);
        idx_d  = idx_q;
        if (scan_q == CW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        nib = 4'd0;
        for (int k = 0; k < int'(DIGITS - 1); k++) begin
            if (idx_d == IW'(k)) nib = disp_d[4*k +: 4];
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Blank if this and every higher magnitude nibble is zero; digit 0 never blanks
        blank = (idx_d != '0);
        for (int k = 0; k < int'(DIGITS - 1); k++) begin
            if (k >= int'(idx_d) && disp_d[4*k +: 4] != 4'd0) blank = 1'b0;
        end
`else
        blank = 1'b0;
`endif
        if (idx_d == IW'(DIGITS - 1)) font_d = disp_neg_d ? 8'hBF : 8'hFF;
        else if (blank)               font_d = 8'hFF;
        else                          font_d = seg7(nib);
    end

    // All datapath and scan registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            bin_q      <= '0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            cc_q       <= 1'b0;
            cnt_q      <= '0;
            disp_q     <= '0;
            disp_neg_q <= 1'b0;
            c_q        <= 1'b0;
            scan_q     <= '0;
            idx_q      <= '0;
            font_q     <= 8'hC0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            mode_q     <= mode_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            cc_q       <= cc_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            disp_neg_q <= disp_neg_d;
            c_q        <= c_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            font_q     <= font_d;
        end
    end

    assign o_c     = c_q;
    assign o_digit = ~(DIGITS'(1) << idx_q);
    assign o_font  = font_q;

endmodule

// File: tb/tb_addsub_bcd_fnd_scan.sv
// Directed bench for addsub_bcd_fnd_scan (WIDTH=8, DIGITS=4, SCAN_DIV=4)
// with a scoreboard of expected carry and per-digit fonts.
module tb_addsub_bcd_fnd_scan;

    localparam int W = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_mode = 1'b0;
    logic [7:0] i_a = '0;
    logic [7:0] i_b = '0;
    logic       o_busy, o_done, o_c;
    logic [3:0] o_digit;
    logic [7:0] o_font;

    addsub_bcd_fnd_scan #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_mode  (i_mode),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_c     (o_c),
        .o_digit (o_digit),
        .o_font  (o_font)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        c;
        logic [31:0] fonts;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_assert = 0;
    int   n_fail = 0;
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic exp_t model(input int a, input int b, input bit mode);
        exp_t e;
        int   r;
        int   d [3];
        bit   neg;
        neg = 1'b0;
        if (!mode) begin
            r = a + b;
            e.c = (r > 255);
        end else if (a >= b) begin
            r = a - b;
            e.c = 1'b0;
        end else begin
            r = b - a;
            e.c = 1'b1;
            neg = 1'b1;
        end
        d[0] = r % 10;
        d[1] = (r / 10) % 10;
        d[2] = (r / 100) % 10;
        for (int i = 0; i < 3; i++) e.fonts[8*i +: 8] = seg_tab[d[i]];
`ifdef LEADING_ZERO_BLANK_EN
        if (d[2] == 0) e.fonts[23:16] = 8'hFF;
        if (d[2] == 0 && d[1] == 0) e.fonts[15:8] = 8'hFF;
`endif
        e.fonts[31:24] = neg ? 8'hBF : 8'hFF;
        return e;
    endfunction

    // Pulse start for one cycle; returns in cycle 1 after the sampling edge
    task automatic launch(input int a, input int b, input bit mode, input bit push);
        i_a = 8'(a);
        i_b = 8'(b);
        i_mode = mode;
        i_start = 1'b1;
        if (push) sb.push_back(model(a, b, mode));
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 1;
        while (!o_done && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, W + 3);
    endtask

    task automatic check_digits(input string tag, input exp_t e);
        logic [3:0] want;
        int k;
        for (int p = 0; p < 4; p++) begin
            want = ~(4'b0001 << p);
            k = 0;
            while (o_digit !== want && k < 32) begin
                step();
                k++;
            end
            check({tag, "_digit", string'(8'(48 + p))}, o_digit, want);
            check({tag, "_font", string'(8'(48 + p))}, o_font, e.fonts[8*p +: 8]);
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            cur_exp = sb.pop_front();
            check({tag, "_done"}, o_done, 1);
            check({tag, "_c"}, o_c, cur_exp.c);
            step();
            check({tag, "_done_pulse"}, o_done, 0);
            check({tag, "_busy_clear"}, o_busy, 0);
            check_digits(tag, cur_exp);
        end
    endtask

    task automatic run_op(input string tag, input int a, input int b, input bit mode);
        launch(a, b, mode, 1'b1);
        check({tag, "_busy"}, o_busy, 1);
        check({tag, "_no_early_done"}, o_done, 0);
        wait_done(tag);
        check_result(tag);
    endtask

    initial begin
        logic [3:0] cur;
        int held, k, dones, pidx;

        #12;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_c", o_c, 0);
        check("rst_digit", o_digit, 4'b1110);
        check("rst_font", o_font, 8'hC0);
        i_rst_n = 1'b1;
        step();

        run_op("add_200_100", 200, 100, 1'b0);
        run_op("sub_3_7", 3, 7, 1'b1);
        run_op("sub_200_55", 200, 55, 1'b1);
        run_op("add_255_255", 255, 255, 1'b0);
        run_op("add_5_0", 5, 0, 1'b0);

        // Reset mid-conversion
        launch(120, 7, 1'b1, 1'b1);
        repeat (4) step();
        check("midrst_busy_before", o_busy, 1);
        i_rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_done", o_done, 0);
        check("midrst_c", o_c, 0);
        check("midrst_digit", o_digit, 4'b1110);
        check("midrst_font", o_font, 8'hC0);
        step();
        i_rst_n = 1'b1;
        step();
        run_op("add_1_1", 1, 1, 1'b0);

        // Start while busy is ignored
        launch(9, 0, 1'b0, 1'b1);
        step();
        step();
        i_a = 8'd1;
        i_b = 8'd1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        dones = 0;
        k = 4;
        while (!o_done && k < 40) begin
            step();
            k++;
        end
        check("busy_ign_latency", k, W + 3);
        check_result("busy_ign");
        for (int i = 0; i < 20; i++) begin
            if (o_done) dones++;
            step();
        end
        check("busy_ign_extra_done", dones, 0);

        // Scan timing: each position held exactly SCAN_DIV cycles, font follows digit
        cur = o_digit;
        k = 0;
        while (o_digit === cur && k < 16) begin
            step();
            k++;
        end
        for (int s = 0; s < 5; s++) begin
            cur = o_digit;
            pidx = 0;
            for (int p = 0; p < 4; p++) if (!cur[p]) pidx = p;
            check("scan_font", o_font, cur_exp.fonts[8*pidx +: 8]);
            held = 0;
            while (o_digit === cur && held < 16) begin
                step();
                held++;
            end
            check("scan_hold", held, 4);
            check("scan_next", o_digit, {cur[2:0], cur[3]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
